// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter for the single register-file write port; masks zero-register writes, counts commits.
// Latency: request sampled at edge E gives ack/writeEnable/writeAddr/writeData registered after E.
// Backpressure: requesters hold req until ack; an acked requester is masked for one cycle.
module regwrite_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    reqAddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    reqData,
    output logic [NUM_REQ-1:0]               ack,
    output logic                             writeEnable,
    output logic [ADDR_WIDTH-1:0]            writeAddr,
    output logic [DATA_WIDTH-1:0]            writeData,
    output logic [15:0]                      writeCount
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '1;

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         ptr_nxt;
    logic [NUM_REQ-1:0]    eligible;
    logic                  grant_vld;
    logic [PW-1:0]         grant_idx;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  write_nxt;

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_arr[i] = reqData[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // A requester acked this cycle still shows req high; masking it prevents a double grant.
    assign eligible = req & ~ack;

    // Scan from the far end backwards so the last hit is the first index at or after ptr.
    always_comb begin
        logic [PW-1:0] cand;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % NUM_REQ);
            if (eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_oh   = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
        grant_addr = addr_arr[grant_idx];
        grant_data = data_arr[grant_idx];
        write_nxt  = grant_vld && (grant_addr != ZERO_REG);
        ptr_nxt    = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr         <= '0;
            ack         <= '0;
            writeEnable <= 1'b0;
            writeAddr   <= '0;
            writeData   <= '0;
            writeCount  <= '0;
        end else begin
            ack         <= grant_oh;
            writeEnable <= write_nxt;
            if (grant_vld) begin
                writeAddr <= grant_addr;
                writeData <= grant_data;
                ptr       <= ptr_nxt;
            end
            if (write_nxt && (writeCount != 16'hFFFF)) begin
                writeCount <= writeCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Randomized and directed bench for regwrite_arbiter against a behavioural round-robin model.
module tb_regwrite_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] reqAddr;
    logic [N*DW-1:0] reqData;
    logic [N-1:0]    ack;
    logic            writeEnable;
    logic [AW-1:0]   writeAddr;
    logic [DW-1:0]   writeData;
    logic [15:0]     writeCount;

    regwrite_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .req(req), .reqAddr(reqAddr), .reqData(reqData),
        .ack(ack), .writeEnable(writeEnable), .writeAddr(writeAddr),
        .writeData(writeData), .writeCount(writeCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t q [N][$];
    wr_t drv_w;
    wr_t rnd_w;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending set minus last winners, first one found walking round from the pointer.
    int            m_ptr  = 0;
    logic [N-1:0]  m_ack  = '0;
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [15:0]   m_cnt  = '0;
    int            mg;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ptr = 0; m_ack = '0; m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = '0;
        end else begin
            mg = -1;
            for (int k = 0; k < N; k++) begin
                if (mg < 0 && req[(m_ptr + k) % N] && !m_ack[(m_ptr + k) % N]) mg = (m_ptr + k) % N;
            end
            if (mg >= 0) begin
                m_ack  = '0;
                m_ack[mg] = 1'b1;
                m_addr = reqAddr[mg*AW +: AW];
                m_data = reqData[mg*DW +: DW];
                m_we   = (m_addr != 5'd31);
                m_ptr  = (mg + 1) % N;
            end else begin
                m_ack = '0;
                m_we  = 1'b0;
            end
            if (m_we && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    end

    // Downstream register file fed from the DUT's write port.
    logic [DW-1:0] rf_dut [32];
    always @(posedge clk) begin
        if (writeEnable === 1'b1) rf_dut[writeAddr] = writeData;
    end

    bit            cmp_en = 1'b0;
    bit            log_en = 1'b0;
    int            log_idx  [$];
    bit            log_we   [$];
    logic [15:0]   log_wc   [$];
    logic [DW-1:0] log_data [$];
    bit            cyc_we   [$];
    int            li;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ack", 64'(ack), 64'(m_ack));
            chk("writeEnable", 64'(writeEnable), 64'(m_we));
            chk("writeAddr", 64'(writeAddr), 64'(m_addr));
            chk("writeData", writeData, m_data);
            chk("writeCount", 64'(writeCount), 64'(m_cnt));
        end
        if (log_en) begin
            cyc_we.push_back(writeEnable);
            if (ack != '0) begin
                li = -1;
                for (int i = 0; i < N; i++) if (ack[i]) li = i;
                log_idx.push_back(li);
                log_we.push_back(writeEnable);
                log_wc.push_back(writeCount);
                log_data.push_back(writeData);
            end
        end
    end

    // Requester agents: hold until acked, then present the next queued write or drop.
    bit drv_en = 1'b0;
    bit flood  = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (drv_en) begin
                for (int i = 0; i < N; i++) begin
                    if (!req[i] || m_ack[i]) begin
                        if (q[i].size() > 0) begin
                            drv_w = q[i].pop_front();
                            req[i] = 1'b1;
                            reqAddr[i*AW +: AW] = drv_w.addr;
                            reqData[i*DW +: DW] = drv_w.data;
                        end else if (flood) begin
                            req[i] = 1'b1;
                            reqAddr[i*AW +: AW] = AW'($urandom_range(0, 30));
                            reqData[i*DW +: DW] = {$urandom, $urandom};
                        end else begin
                            req[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    function automatic wr_t mk(input int a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = AW'(a);
        w.data = d;
        return w;
    endfunction

    task automatic clear_logs();
        log_idx.delete(); log_we.delete(); log_wc.delete(); log_data.delete(); cyc_we.delete();
    endtask

    task automatic wait_idle(input int max_cyc);
        int  n;
        bit  idle;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            idle = (req == '0) && (m_ack == '0) && !m_we;
            for (int i = 0; i < N; i++) if (q[i].size() != 0) idle = 1'b0;
        end while (!idle && n < max_cyc);
        chk("wait_idle_timeout", 64'(!idle), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
    endtask

    int exp_rr [5] = '{0, 1, 2, 3, 0};
    bit exp_we [5] = '{1, 0, 1, 0, 1};
    int first_we;
    int ncyc;
    int rq;

    initial begin
        reset = 1'b0; req = '0; reqAddr = '0; reqData = '0;
        cmp_en = 1'b1;
        #23 reset = 1'b1;

        // Asynchronous reset with all four requesting.
        @(posedge clk); #1;
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            reqAddr[i*AW +: AW] = AW'(i + 1);
            reqData[i*DW +: DW] = DW'(10 * (i + 1));
        end
        @(posedge clk); #3;
        chk("pre_reset_ack", 64'(ack), 64'h1);
        reset = 1'b0;
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_we", 64'(writeEnable), 64'd0);
        chk("rst_addr", 64'(writeAddr), 64'd0);
        chk("rst_data", writeData, 64'd0);
        chk("rst_count", 64'(writeCount), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ack", 64'(ack), 64'h1);
        chk("post_rst_addr", 64'(writeAddr), 64'd1);
        chk("post_rst_data", writeData, 64'd10);
        req = '0;
        @(posedge clk); #1;
        drv_en = 1'b1;
        wait_idle(20);
        do_reset();

        // Round-robin with everyone busy.
        clear_logs(); log_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            q[i].push_back(mk(i + 1, DW'(10 * (i + 1))));
            q[i].push_back(mk(i + 1, DW'(10 * (i + 1))));
        end
        wait_idle(50);
        log_en = 1'b0;
        chk("rr_grants", 64'(log_idx.size()), 64'd8);
        if (log_idx.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("rr_grant%0d", k), 64'(log_idx[k]), 64'(exp_rr[k]));
            chk("rr_count4", 64'(log_wc[3]), 64'd4);
        end

        // Single continuous requester.
        clear_logs(); log_en = 1'b1;
        q[2].push_back(mk(9, 64'd5));
        q[2].push_back(mk(9, 64'd6));
        q[2].push_back(mk(9, 64'd7));
        wait_idle(50);
        log_en = 1'b0;
        chk("single_grants", 64'(log_idx.size()), 64'd3);
        first_we = -1;
        for (int k = cyc_we.size() - 1; k >= 0; k--) if (cyc_we[k]) first_we = k;
        chk("single_we_window", 64'(first_we >= 0 && first_we + 5 <= cyc_we.size()), 64'd1);
        if (first_we >= 0 && first_we + 5 <= cyc_we.size())
            for (int k = 0; k < 5; k++) chk($sformatf("single_we%0d", k), 64'(cyc_we[first_we + k]), 64'(exp_we[k]));
        if (log_data.size() == 3)
            for (int k = 0; k < 3; k++) chk($sformatf("single_data%0d", k), log_data[k], 64'(5 + k));

        // Zero register write is acked but suppressed.
        clear_logs(); log_en = 1'b1;
        q[1].push_back(mk(31, 64'hDEAD));
        wait_idle(20);
        log_en = 1'b0;
        chk("zr_grants", 64'(log_idx.size()), 64'd1);
        if (log_idx.size() == 1) begin
            chk("zr_ack_idx", 64'(log_idx[0]), 64'd1);
            chk("zr_we", 64'(log_we[0]), 64'd0);
            chk("zr_count", 64'(log_wc[0]), 64'd11);
        end

        // Pointer moved past requester 1, so 3 wins over 0.
        clear_logs(); log_en = 1'b1;
        q[0].push_back(mk(2, 64'd1));
        q[3].push_back(mk(3, 64'd2));
        wait_idle(20);
        log_en = 1'b0;
        chk("ptr_grants", 64'(log_idx.size()), 64'd2);
        if (log_idx.size() == 2) begin
            chk("ptr_first", 64'(log_idx[0]), 64'd3);
            chk("ptr_second", 64'(log_idx[1]), 64'd0);
        end

        // Same address from 0 and 3 with the pointer at 3.
        q[2].push_back(mk(8, 64'd3));
        wait_idle(20);
        clear_logs(); log_en = 1'b1;
        q[0].push_back(mk(7, 64'd100));
        q[3].push_back(mk(7, 64'd200));
        wait_idle(20);
        log_en = 1'b0;
        chk("same_grants", 64'(log_idx.size()), 64'd2);
        if (log_idx.size() == 2) begin
            chk("same_first", 64'(log_idx[0]), 64'd3);
            chk("same_second", 64'(log_idx[1]), 64'd0);
        end
        chk("same_rf7", rf_dut[7], 64'd100);
        chk("same_count", 64'(writeCount), 64'd16);

        // Random traffic, zero-register address weighted up.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                rq = $urandom_range(0, N - 1);
                rnd_w.addr = ($urandom_range(0, 3) == 0) ? 5'd31 : AW'($urandom_range(0, 31));
                rnd_w.data = {$urandom, $urandom};
                if (q[rq].size() < 3) q[rq].push_back(rnd_w);
            end
        end
        wait_idle(200);

        // Saturation of the commit counter.
        do_reset();
        flood = 1'b1;
        ncyc = 0;
        while (m_cnt != 16'hFFFF && ncyc < 70000) begin
            @(negedge clk);
            ncyc++;
        end
        chk("sat_reach_timeout", 64'(m_cnt != 16'hFFFF), 64'd0);
        flood = 1'b0;
        wait_idle(50);
        chk("sat_count", 64'(writeCount), 64'hFFFF);
        clear_logs(); log_en = 1'b1;
        q[1].push_back(mk(5, 64'h55));
        wait_idle(20);
        log_en = 1'b0;
        chk("sat_grants", 64'(log_idx.size()), 64'd1);
        if (log_idx.size() == 1) begin
            chk("sat_we", 64'(log_we[0]), 64'd1);
            chk("sat_hold", 64'(log_wc[0]), 64'hFFFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regwrite_arbiter.md
# regwrite_arbiter

Round-robin arbiter that shares the single write port of the 64-bit register file among several requesters (ALU writeback, load unit, link-register writer, and so on). Each cycle it picks at most one pending request. It drives the registered `writeEnable`/`writeAddr`/`writeData` for the register file and returns a one-cycle `ack` to the winner. It sits between the writeback sources and the register-file write decoder. It also suppresses writes to the zero register and counts committed writes.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `DATA_WIDTH`, 64: write data width
- `ADDR_WIDTH`, 5: register address width; address `2**ADDR_WIDTH-1` (31) is the zero register
- `clk` input 1: single clock; all state updates on the rising edge
- `reset` input 1: asynchronous, active-low; `reset==0` clears all state immediately
- `req` input NUM_REQ: bit i high means requester i has a write pending
- `reqAddr` input NUM_REQ*ADDR_WIDTH: requester i address in bits `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `reqData` input NUM_REQ*DATA_WIDTH: requester i data in bits `[i*DATA_WIDTH +: DATA_WIDTH]`
- `ack` output NUM_REQ: one-hot or zero; bit i high for exactly one cycle after requester i is granted
- `writeEnable` output 1: register-file write enable, registered
- `writeAddr` output ADDR_WIDTH: register-file write address, registered
- `writeData` output DATA_WIDTH: register-file write data, registered
- `writeCount` output 16: saturating count of committed (non-suppressed) writes

## Operation
- State:
  - priority pointer `ptr` (0..NUM_REQ-1)
  - registered outputs
  - `writeCount`
- Eligible set each cycle is `req & ~ack`. A requester acked this cycle is masked, because it cannot have deasserted `req` yet. This prevents a double grant.
- Grant selection: the first eligible index found scanning `ptr`, `ptr+1`, … with wrap modulo NUM_REQ.
- On a rising edge with grant g:
  - `ack` <= one-hot(g).
  - `writeAddr` <= `reqAddr[g]` and `writeData` <= `reqData[g]`.
  - `writeEnable` <= 1, unless `reqAddr[g]` == 31, in which case `writeEnable` <= 0. The zero-register write is still acked.
  - `ptr` <= (g+1) mod NUM_REQ.
- On a rising edge with no eligible requester:
  - `ack` <= 0 and `writeEnable` <= 0.
  - `writeAddr` and `writeData` hold their values.
  - `ptr` holds.
- `writeCount` increments on every edge where the new `writeEnable` is 1. It saturates at 16'hFFFF and does not wrap.
- Requester protocol:
  - Hold `req`, `reqAddr` and `reqData` stable until `ack` is seen.
  - At the edge ending the ack cycle, either drop `req` or present the next write.
  - Changing address or data while `req` is high and unacked is illegal; the value sampled at the grant edge is the one used.
- Two requesters targeting the same address are granted on different cycles in round-robin order. The later grant's data is what the register holds.
- Reset (`reset==0`, asynchronous):
  - `ack`=0, `writeEnable`=0, `writeAddr`=0, `writeData`=0, `writeCount`=0, `ptr`=0.
  - A grant in flight is discarded: no ack and no write.
  - Requesters must re-present after reset deasserts.

## Timing
- Latency: `req` sampled at edge E produces `ack` and `writeEnable` high during cycle E..E+1. The register file captures at edge E+1, and data is readable from the register after E+1.
- Throughput: one write per cycle when at least two requesters are active. A single continuously-requesting source gets a grant every second cycle because of the ack mask.
- Fairness bound: a requester holding `req` is granted within NUM_REQ edges.
- The selection logic is purely combinational from `req`, `ack` and `ptr`. All outputs are flops, so there is no combinational path from `req` to any output.
- Reset deassertion: the first grant can occur on the first rising edge after `reset` returns high.

## Test plan
- **Reset:** drive `reset`=0 mid-cycle with `req`=4'b1111 -> all outputs 0 immediately. After release, requester 0 is granted first, and `writeAddr`/`writeData` equal requester 0's values one edge later.
- **Round-robin:** all four requesters hold addresses 1..4 with data 10..40 -> grants 0,1,2,3,0 on consecutive edges, each `ack` one cycle wide, `writeCount`=4 after four grants.
- **Single requester:** requester 2 holds `req` continuously, re-presenting data 5, 6, 7 after each ack -> `writeEnable` pattern 1,0,1,0,1 with one grant per ack and no duplicate write of the same data.
- **Zero register:** requester 1 writes address 31 with data 64'hDEAD -> `ack[1]`=1, `writeEnable`=0, `writeCount` unchanged, `ptr` advances to 2.
- **Same address:** requesters 0 and 3 both target address 7 with data 100 and 200, `ptr`=3 -> 3 is granted first, then 0. The register-file model holds 100 afterwards.
- **Saturation:** preload `writeCount` near the limit via 65535 grants, then one more grant -> `writeCount` stays at 16'hFFFF.
